// File: rtl/keccak_state_stream_buffer.sv
// Keccak state buffer: serial valid/ready load, parallel capture and exposure,
// serial valid/ready unload in forward or reverse word order.
module keccak_state_stream_buffer #(
  parameter int WORD_W     = 25,
  parameter int DEPTH      = 64,
  parameter int UNLOAD_REV = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_load,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    capture,
  input  logic [WORD_W*DEPTH-1:0] state_in,
  input  logic                    start_unload,
  output logic                    out_valid,
  output logic [WORD_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    state_valid,
  output logic [WORD_W*DEPTH-1:0] state_out,
  output logic                    load_done,
  output logic                    unload_done,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] FIRST_OUT = (UNLOAD_REV != 0) ? LAST_IDX : '0;
  localparam logic [IDX_W-1:0] FINAL_OUT = (UNLOAD_REV != 0) ? '0 : LAST_IDX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FULL   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] words [DEPTH];
  logic              wr_en, cap_en;
  logic              load_done_nxt, unload_done_nxt;

  // Handshakes: a word moves on a rising edge where valid && ready are both 1.
  // in_ready and out_valid are Moore outputs of the state, so neither side
  // may make its valid/ready depend combinationally on the other.
  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == UNLOAD);
  assign busy        = (state == LOAD) || (state == UNLOAD);
  assign state_valid = (state == FULL) || (state == UNLOAD);
  assign out_data    = words[idx];
  assign dbg_state   = state;

  always_comb begin
    state_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      state_out[i*WORD_W +: WORD_W] = words[i];
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    wr_en           = 1'b0;
    cap_en          = 1'b0;
    load_done_nxt   = 1'b0;
    unload_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end else if (capture) begin
          state_nxt = FULL;
          cap_en    = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt     = FULL;
            idx_nxt       = '0;
            load_done_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (start_load) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end else if (capture) begin
          cap_en = 1'b1;
        end else if (start_unload) begin
          state_nxt = UNLOAD;
          idx_nxt   = FIRST_OUT;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (idx == FINAL_OUT) begin
            state_nxt       = FULL;
            idx_nxt         = '0;
            unload_done_nxt = 1'b1;
          end else if (UNLOAD_REV != 0) begin
            idx_nxt = idx - IDX_W'(1);
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      load_done   <= 1'b0;
      unload_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      load_done   <= load_done_nxt;
      unload_done <= unload_done_nxt;
      if (cap_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          words[i] <= state_in[i*WORD_W +: WORD_W];
        end
      end else if (wr_en) begin
        words[idx] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_keccak_state_stream_buffer.sv
// Bench for keccak_state_stream_buffer: forward and reversed instances share
// stimulus; expectations come from a word-array model and expected queues.
module tb_keccak_state_stream_buffer;

  localparam int W  = 25;
  localparam int D  = 64;
  localparam int SW = W * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load, in_valid, capture, start_unload, out_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] state_in;

  logic          f_in_ready, f_out_valid, f_state_valid, f_load_done, f_unload_done, f_busy;
  logic [W-1:0]  f_out_data;
  logic [SW-1:0] f_state_out;
  logic [1:0]    f_dbg_state;
  logic          r_in_ready, r_out_valid, r_state_valid, r_load_done, r_unload_done, r_busy;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_state_out;
  logic [1:0]    r_dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] ld_data     [D];
  logic [W-1:0] model_words [D];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rq[$];

  // clock / reset
  always #5 clk = ~clk;

  keccak_state_stream_buffer #(.WORD_W(W), .DEPTH(D), .UNLOAD_REV(0)) dut_f (
    .clk(clk), .rst(rst), .start_load(start_load), .in_valid(in_valid),
    .in_data(in_data), .in_ready(f_in_ready), .capture(capture), .state_in(state_in),
    .start_unload(start_unload), .out_valid(f_out_valid), .out_data(f_out_data),
    .out_ready(out_ready), .state_valid(f_state_valid), .state_out(f_state_out),
    .load_done(f_load_done), .unload_done(f_unload_done), .busy(f_busy),
    .dbg_state(f_dbg_state)
  );

  keccak_state_stream_buffer #(.WORD_W(W), .DEPTH(D), .UNLOAD_REV(1)) dut_r (
    .clk(clk), .rst(rst), .start_load(start_load), .in_valid(in_valid),
    .in_data(in_data), .in_ready(r_in_ready), .capture(capture), .state_in(state_in),
    .start_unload(start_unload), .out_valid(r_out_valid), .out_data(r_out_data),
    .out_ready(out_ready), .state_valid(r_state_valid), .state_out(r_state_out),
    .load_done(r_load_done), .unload_done(r_unload_done), .busy(r_busy),
    .dbg_state(r_dbg_state)
  );

  function automatic logic [SW-1:0] pack_model();
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = model_words[i];
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic clear_inputs();
    start_load = 0; in_valid = 0; capture = 0; start_unload = 0; out_ready = 0;
    in_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    state_in = '0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({f_state_valid, f_in_ready, f_out_valid, f_busy, f_load_done, f_unload_done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 000000",
               {f_state_valid, f_in_ready, f_out_valid, f_busy, f_load_done, f_unload_done});
    end
    tests_run++;
    if (f_state_out !== '0 || r_state_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_state_out got nonzero want 0");
    end
    for (int i = 0; i < D; i++) model_words[i] = '0;
    rst = 1;
  endtask

  task automatic test_idle_ignore();
    start_unload = 1;
    @(posedge clk); #1;
    start_unload = 0;
    tests_run++;
    if ({f_out_valid, f_state_valid, f_busy} !== 3'b0) begin
      tests_failed++;
      $display("FAIL idle_unload_ignored got %b want 000", {f_out_valid, f_state_valid, f_busy});
    end
  endtask

  // mode 0: in_valid held, 1: every other cycle, 2: random. Stops after n_words.
  task automatic do_load(input int mode, input int n_words);
    int   n, cyc, exp_cyc;
    logic hs;
    logic [SW-1:0] old;
    old = pack_model();
    state_in = rand_state();
    start_load = 1; capture = 1; start_unload = 1;
    @(posedge clk); #1;
    capture = 0; start_unload = 0; start_load = 0;
    tests_run++;
    if (f_in_ready !== 1'b1 || f_state_valid !== 1'b0 || f_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_start got ready=%b valid=%b busy=%b want 1 0 1",
               f_in_ready, f_state_valid, f_busy);
    end
    tests_run++;
    if (f_state_out !== old) begin
      tests_failed++;
      $display("FAIL load_start_retain got %h want %h", f_state_out[W-1:0], old[W-1:0]);
    end
    n = 0; cyc = 0;
    while (n < n_words && cyc < 1000) begin
      in_valid     = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      in_data      = ld_data[n];
      start_load   = 1'($urandom_range(0, 1));
      capture      = 1'($urandom_range(0, 1));
      start_unload = 1'($urandom_range(0, 1));
      tests_run++;
      if (f_in_ready !== 1'b1 || r_in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_in_ready word %0d got %b/%b want 1", n, f_in_ready, r_in_ready);
      end
      hs = in_valid && f_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        model_words[n] = ld_data[n];
        n++;
      end
      tests_run++;
      if (f_load_done !== (hs && n == D) || r_load_done !== (hs && n == D)) begin
        tests_failed++;
        $display("FAIL load_done word %0d got %b/%b want %b", n, f_load_done, r_load_done, hs && n == D);
      end
    end
    clear_inputs();
    tests_run++;
    if (n != n_words) begin
      tests_failed++;
      $display("FAIL load_timeout got %0d words want %0d", n, n_words);
    end
    if (n_words == D) begin
      if (mode < 2) begin
        exp_cyc = (mode == 0) ? D : 2 * D;
        tests_run++;
        if (cyc != exp_cyc) begin
          tests_failed++;
          $display("FAIL load_cycles got %0d want %0d", cyc, exp_cyc);
        end
      end
      tests_run++;
      if (f_state_valid !== 1'b1 || f_busy !== 1'b0 || f_in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_end got valid=%b busy=%b ready=%b want 1 0 0", f_state_valid, f_busy, f_in_ready);
      end
      tests_run++;
      if (f_state_out !== pack_model() || r_state_out !== pack_model()) begin
        tests_failed++;
        $display("FAIL load_contents got w0=%h w63=%h want w0=%h w63=%h",
                 f_state_out[W-1:0], f_state_out[SW-1 -: W], model_words[0], model_words[D-1]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (f_load_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL load_done_pulse got %b want 0", f_load_done);
      end
    end
  endtask

  task automatic do_capture(input logic [SW-1:0] val);
    state_in = val; capture = 1; start_unload = 1;
    @(posedge clk); #1;
    capture = 0; start_unload = 0;
    for (int i = 0; i < D; i++) model_words[i] = val[i*W +: W];
    tests_run++;
    if (f_state_valid !== 1'b1 || f_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL capture_flags got valid=%b out_valid=%b want 1 0", f_state_valid, f_out_valid);
    end
    tests_run++;
    if (f_state_out !== val || r_state_out !== val) begin
      tests_failed++;
      $display("FAIL capture_contents got %h want %h", f_state_out[W-1:0], val[W-1:0]);
    end
  endtask

  // rmode 0: out_ready held, 1: random. Stalls stall_len cycles after stall_at words.
  task automatic do_unload(input int rmode, input int stall_at, input int stall_len);
    int   sent, stall, cyc;
    logic hs;
    exp_q.delete(); exp_rq.delete();
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(model_words[i]);
      exp_rq.push_back(model_words[D-1-i]);
    end
    state_in = rand_state();
    start_unload = 1;
    @(posedge clk); #1;
    start_unload = 0;
    sent = 0; stall = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      if (sent == stall_at && stall < stall_len) begin
        out_ready = 0; start_load = 1; capture = 1; stall++;
      end else begin
        out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        start_load = 0; capture = 0;
      end
      tests_run++;
      if (f_out_valid !== 1'b1 || r_out_valid !== 1'b1 || f_state_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL unload_valid word %0d got %b/%b sv=%b want 1", sent, f_out_valid, r_out_valid, f_state_valid);
      end
      tests_run++;
      if (f_out_data !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL unload_fwd_data word %0d got %h want %h", sent, f_out_data, exp_q[0]);
      end
      tests_run++;
      if (r_out_data !== exp_rq[0]) begin
        tests_failed++;
        $display("FAIL unload_rev_data word %0d got %h want %h", sent, r_out_data, exp_rq[0]);
      end
      hs = out_ready && f_out_valid;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        void'(exp_q.pop_front());
        void'(exp_rq.pop_front());
        sent++;
      end
      tests_run++;
      if (f_unload_done !== (hs && sent == D) || r_unload_done !== (hs && sent == D)) begin
        tests_failed++;
        $display("FAIL unload_done word %0d got %b/%b want %b", sent, f_unload_done, r_unload_done, hs && sent == D);
      end
    end
    clear_inputs();
    tests_run++;
    if (sent != D) begin
      tests_failed++;
      $display("FAIL unload_timeout got %0d words want %0d", sent, D);
    end
    tests_run++;
    if (f_state_valid !== 1'b1 || f_out_valid !== 1'b0 || f_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL unload_end got sv=%b ov=%b busy=%b want 1 0 0", f_state_valid, f_out_valid, f_busy);
    end
    tests_run++;
    if (f_state_out !== pack_model()) begin
      tests_failed++;
      $display("FAIL unload_retain got %h want %h", f_state_out[W-1:0], model_words[0]);
    end
  endtask

  task automatic fill_seq();
    for (int i = 0; i < D; i++) ld_data[i] = W'(i + 1);
  endtask

  task automatic test_load_stream();
    fill_seq();
    do_load(0, D);
    tests_run++;
    if (f_state_out[W-1:0] !== 25'd1 || f_state_out[SW-1 -: W] !== 25'd64) begin
      tests_failed++;
      $display("FAIL load_layout got w0=%0d w63=%0d want 1 64", f_state_out[W-1:0], f_state_out[SW-1 -: W]);
    end
  endtask

  task automatic test_load_gapped();
    fill_seq();
    do_load(1, D);
  endtask

  task automatic test_capture_unload();
    logic [SW-1:0] v;
    v = {D{25'h1555555}};
    rst = 0; #2; rst = 1;
    for (int i = 0; i < D; i++) model_words[i] = '0;
    @(posedge clk); #1;
    do_capture(v);
    do_unload(0, -1, 0);
  endtask

  task automatic test_unload_stall();
    fill_seq();
    do_load(0, D);
    do_unload(0, 10, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < D; i++) ld_data[i] = W'($urandom);
    do_load(2, D);
    do_unload(1, -1, 0);
    do_unload(0, $urandom_range(0, D - 1), 3);
    do_capture(rand_state());
    do_unload(1, -1, 0);
  endtask

  task automatic test_reset_mid();
    fill_seq();
    do_load(0, 30);
    #2 rst = 0;
    #1;
    tests_run++;
    if ({f_state_valid, f_in_ready, f_out_valid, f_busy, f_load_done, f_unload_done} !== 6'b0
        || f_state_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid got flags=%b w0=%h want 0",
               {f_state_valid, f_in_ready, f_out_valid, f_busy, f_load_done, f_unload_done},
               f_state_out[W-1:0]);
    end
    for (int i = 0; i < D; i++) model_words[i] = '0;
    #2 rst = 1;
    @(posedge clk); #1;
    do_load(0, D);
    do_unload(0, -1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_load_stream();
    test_load_gapped();
    test_capture_unload();
    test_unload_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keccak_state_stream_buffer.md
Name: keccak_state_stream_buffer

Overview:
- Parametrised successor to the file-backed Keccak state source: a synthesizable, handshaked state buffer.
- Loads a Keccak state of DEPTH words × WORD_W bits serially (valid/ready), exposes it in parallel, captures a parallel state from the datapath, and streams it back out serially.
- Sits between the testbench/host stream and the round datapath (theta/rho/pi/chi/iota stages).

Parameters:
- WORD_W, 25, bits per word (one Keccak slice).
- DEPTH, 64, words per state. state width = WORD_W*DEPTH.
- UNLOAD_REV, 0, unload order: 0 = word 0 first, 1 = word DEPTH-1 first.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_load  in  1  command: begin serial load
- in_valid  in  1  input word valid
- in_data  in  WORD_W  input word
- in_ready  out  1  buffer accepts in_data
- capture  in  1  command: parallel-capture state_in
- state_in  in  WORD_W*DEPTH  parallel state from datapath
- start_unload  in  1  command: begin serial unload
- out_valid  out  1  out_data valid
- out_data  out  WORD_W  output word
- out_ready  in  1  downstream accepts out_data
- state_valid  out  1  buffer holds a complete state
- state_out  out  WORD_W*DEPTH  parallel state
- load_done  out  1  one-cycle pulse, last word loaded
- unload_done  out  1  one-cycle pulse, last word sent
- busy  out  1  state is LOAD or UNLOAD

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE, index=0, all words=0.
  - state_valid, in_ready, out_valid, load_done, unload_done, busy all 0; state_out=0.
- Layout:
  - word i occupies state_out[i*WORD_W +: WORD_W].
  - in_data MSB maps to the field MSB.
  - The first loaded word is word 0.
- FSM states: IDLE, LOAD, FULL, UNLOAD. Index counter width clog2(DEPTH).
- IDLE:
  - start_load → LOAD, index=0.
  - else capture → FULL: all words=state_in, state_valid=1 next cycle.
  - start_unload ignored (no valid state).
- LOAD:
  - in_ready=1 (Moore, from state).
  - On in_valid&&in_ready: word[index]=in_data, index++.
  - On the handshake with index==DEPTH-1: → FULL, state_valid=1 and load_done=1 in the next cycle.
  - in_valid low stalls without side effects.
  - capture, start_load and start_unload are ignored.
- FULL:
  - state_valid=1.
  - Priority per cycle: start_load > capture > start_unload.
  - start_load → LOAD, index=0, state_valid=0 next cycle; old words are retained until overwritten.
  - capture overwrites all words and stays in FULL.
  - start_unload → UNLOAD, index = 0 (UNLOAD_REV=0) or DEPTH-1 (UNLOAD_REV=1).
- UNLOAD:
  - out_valid=1; out_data=word[index] combinationally from registered index and words.
  - On out_valid&&out_ready: index steps +1 (or −1 when UNLOAD_REV=1).
  - Handshake on the final word (DEPTH-1, or 0 when reversed): → FULL, unload_done=1 next cycle.
  - state_valid stays 1 and the buffer is unchanged, so re-unload is allowed.
  - out_ready low holds out_data stable.
  - All commands are ignored.
- Timing and protocol:
  - Throughput: one word per cycle in both directions.
  - Load latency: state_valid rises the cycle after the DEPTH-th input handshake.
- Reset mid-operation: immediate return to reset values; a partial load is discarded (words zeroed).
- Width rules:
  - Index arithmetic has no wrap beyond DEPTH-1; the terminal compare forces the state exit.
  - DEPTH need not be a power of two.

Test Plan:
- Reset, then stream 64 words, word i = i+1 (25-bit), in_valid held 1 → in_ready 1 for 64 cycles; load_done pulses once; state_out[24:0]=1, state_out[1599:1575]=64; state_valid=1.
- Load with in_valid toggled every other cycle → 64 accepted words, completion after 128 cycles, contents identical to the previous test.
- capture with state_in={64{25'h1555555}} in IDLE → next cycle state_valid=1, state_out equals state_in; then start_unload with out_ready=1 → 64 words 25'h1555555, unload_done pulses, state_valid still 1.
- UNLOAD_REV=1 after loading i+1 → out_data sequence 64,63,…,1.
- During unload, deassert out_ready at word 10 for 5 cycles → out_data holds 11 (forward order), no word skipped or repeated; start_load asserted meanwhile is ignored.
- Assert rst=0 after 30 loaded words → all outputs 0 asynchronously; after release, a 64-word load of i+1 produces correct state_out.
